ctr_block_packer: RTL and testbench
===================================

Name: ctr_block_packer

Overview:
Upstream feeder for the AES-256-CTR decrypt datapath. Accepts ciphertext as a stream of 128-bit blocks over a valid/ready handshake and assembles them into one CIPHERTEXTIN-bit message word. It captures the IV and key that belong to the message and presents message, IV, key and block count to the decrypter as a single held transaction. Messages shorter than the full width are zero-padded.

Parameters:
CIPHERTEXTIN, 1024, message width in bits; must be a non-zero multiple of 128.
NBLK, CIPHERTEXTIN/128, derived (localparam); number of 128-bit blocks per message.
CNT_W, $clog2(NBLK)+1, derived (localparam); width of block index and count.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
s_data  in  128  ciphertext block.
s_valid  in  1  s_data is valid.
s_last  in  1  the current beat is the final block of the message.
s_ready  out  1  the packer accepts a beat this cycle.
iv_in  in  128  initial counter block; sampled only on block 0.
key_in  in  256  AES-256 key; sampled only on block 0.
msg_data  out  CIPHERTEXTIN  assembled message; block i occupies bits [i*128+127 : i*128].
msg_iv  out  128  IV captured with block 0.
msg_key  out  256  key captured with block 0.
msg_nblocks  out  CNT_W  number of valid blocks in msg_data, from 1 to NBLK.
msg_valid  out  1  the message transaction is presented.
msg_ready  in  1  the decrypter takes the message.

Behaviour:
- Reset:
  - rst is synchronous and active-high; clk is the clock.
  - While rst is high: state becomes FILL, idx becomes 0, and msg_data, msg_iv, msg_key, msg_nblocks and msg_valid are all driven 0.
  - s_ready is 0 whenever rst is high.
- Beat acceptance: a beat is accepted when s_valid and s_ready are both high.
- The FSM has two states: FILL and HOLD.
- FILL:
  - s_ready = 1 and msg_valid = 0.
  - On an accepted beat, write msg_data[idx*128 +: 128] <= s_data.
  - If idx == 0, also capture msg_iv <= iv_in and msg_key <= key_in.
  - If s_last == 1 or idx == NBLK-1: set msg_nblocks <= idx+1, set idx <= 0, and go to HOLD.
  - Otherwise idx <= idx+1 and stay in FILL.
- HOLD:
  - s_ready = 0 and msg_valid = 1.
  - msg_data, msg_iv, msg_key and msg_nblocks are held stable.
  - When msg_ready == 1, go to FILL and clear msg_data to 0 on the same edge, so the next message is zero-padded.
  - msg_iv, msg_key and msg_nblocks keep their values until they are overwritten.
- Latency and throughput:
  - msg_valid rises in the cycle after the final beat is accepted.
  - s_ready returns one cycle after the msg_valid/msg_ready handshake.
  - Maximum throughput is one message per (nblocks + 1) cycles.
- s_last is optional on a full message. When NBLK beats arrive without s_last, the message closes automatically. If s_last is also set on beat NBLK-1, the result is the same.
- s_last on the first beat produces a single-block message: msg_nblocks = 1 and blocks 1..NBLK-1 are 0.
- Beats presented while in HOLD are back-pressured (s_ready = 0). They are never dropped or overwritten.
- A change on iv_in or key_in after block 0 has no effect on the current message.
- msg_ready held high while in FILL has no effect.
- Reset asserted mid-fill or during HOLD discards the partial or presented message. After reset the next accepted beat is block 0.
- idx arithmetic is unsigned, CNT_W bits wide, and never exceeds NBLK-1.

Decomposition:
- Shared package ctr_pkg holds:
  - AES_BLK_W = 128 and AES_KEY_W = 256.
  - typedef aes_blk_t (logic [127:0]) and aes_key_t (logic [255:0]).
  - The FSM state enum pk_state_e {PK_FILL, PK_HOLD}.
- No sub-module is needed: the block is a single FSM plus a write-enabled register file.

Test Plan:
1. Full message with NBLK = 8: 8 beats with s_data = 128'h1..128'h8, s_last on beat 8, msg_ready = 0 → msg_valid rises the cycle after beat 8; msg_data[127:0] = 1 and msg_data[1023:896] = 8; msg_nblocks = 8; s_ready = 0 while held.
2. Short message: 3 beats A, B, C with s_last on C → msg_nblocks = 3; bits [383:0] = {C, B, A}; bits [1023:384] = 0. A following 2-block message leaves no residue of C in the padded region.
3. IV/key capture: iv_in = 128'hF0 and key_in = 256'hAB at beat 0, then both change to 0 → msg_iv = 128'hF0 and msg_key = 256'hAB.
4. Back-pressure: hold msg_ready = 0 for 5 cycles with s_valid high → no beats accepted and outputs stable; assert msg_ready for 1 cycle → s_ready = 1 on the next cycle.
5. Full message without s_last: 8 beats → auto-close with msg_nblocks = 8; the 9th beat becomes block 0 of the next message.
6. Reset after beat 4 of 8, then a 1-beat message with s_last → msg_nblocks = 1 and only block 0 is non-zero.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared types and constants for the AES-256-CTR decrypt front end.
package ctr_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 256;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;
    typedef logic [AES_KEY_W-1:0] aes_key_t;

    typedef enum logic {
        PK_FILL = 1'b0,
        PK_HOLD = 1'b1
    } pk_state_e;

endpackage

// File: rtl/ctr_block_packer.sv
// Packs a stream of 128-bit ciphertext blocks into one zero-padded message word
// and presents it, together with the IV and key seen on block 0, as a held transaction.
module ctr_block_packer
    import ctr_pkg::*;
#(
    parameter  int CIPHERTEXTIN = 1024,
    localparam int NBLK         = CIPHERTEXTIN / AES_BLK_W,
    localparam int CNT_W        = $clog2(NBLK) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  aes_blk_t                s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    input  aes_blk_t                iv_in,
    input  aes_key_t                key_in,
    output logic [CIPHERTEXTIN-1:0] msg_data,
    output aes_blk_t                msg_iv,
    output aes_key_t                msg_key,
    output logic [CNT_W-1:0]        msg_nblocks,
    output logic                    msg_valid,
    input  logic                    msg_ready
);

    pk_state_e               state_q;
    logic [CNT_W-1:0]        idx_q;
    logic [CNT_W-1:0]        idx_d;
    logic [CIPHERTEXTIN-1:0] data_q;
    aes_blk_t                iv_q;
    aes_key_t                key_q;
    logic [CNT_W-1:0]        nblocks_q;
    logic                    valid_q;
    logic                    beat_ok;
    logic                    closing;

    assign idx_d   = idx_q + CNT_W'(1);
    assign s_ready = (state_q == PK_FILL) && !rst;
    assign beat_ok = s_valid && s_ready;
    // A message closes on s_last or automatically once the final block slot is written.
    assign closing = s_last || (idx_q == CNT_W'(NBLK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PK_FILL;
            idx_q     <= '0;
            data_q    <= '0;
            iv_q      <= '0;
            key_q     <= '0;
            nblocks_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                PK_FILL: begin
                    if (beat_ok) begin
                        data_q[int'(idx_q)*AES_BLK_W +: AES_BLK_W] <= s_data;
                        if (idx_q == '0) begin
                            iv_q  <= iv_in;
                            key_q <= key_in;
                        end
                        if (closing) begin
                            nblocks_q <= idx_d;
                            idx_q     <= '0;
                            valid_q   <= 1'b1;
                            state_q   <= PK_HOLD;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                PK_HOLD: begin
                    // Clearing the word on release is what zero-pads the next short message.
                    if (msg_ready) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                        state_q <= PK_FILL;
                    end
                end
                default: begin
                    state_q <= PK_FILL;
                end
            endcase
        end
    end

    assign msg_data    = data_q;
    assign msg_iv      = iv_q;
    assign msg_key     = key_q;
    assign msg_nblocks = nblocks_q;
    assign msg_valid   = valid_q && !rst;

endmodule

// File: tb/tb_ctr_block_packer.sv
// Directed-vector bench for ctr_block_packer: stimulus pushes expected messages,
// a monitor pops and compares on every msg_valid/msg_ready handshake.
module tb_ctr_block_packer;

    logic          clk;
    logic          rst;
    logic [127:0]  s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [127:0]  iv_in;
    logic [255:0]  key_in;
    logic [1023:0] msg_data;
    logic [127:0]  msg_iv;
    logic [255:0]  msg_key;
    logic [3:0]    msg_nblocks;
    logic          msg_valid;
    logic          msg_ready;

    typedef struct {
        logic [1023:0] data;
        logic [127:0]  iv;
        logic [255:0]  key;
        logic [3:0]    nb;
    } exp_t;

    exp_t sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    ctr_block_packer #(.CIPHERTEXTIN(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .iv_in       (iv_in),
        .key_in      (key_in),
        .msg_data    (msg_data),
        .msg_iv      (msg_iv),
        .msg_key     (msg_key),
        .msg_nblocks (msg_nblocks),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got timeout expected handshake", name);
    endtask

    // Sends n beats base, base+1, ...; iv/key are only correct on beat 0 so late sampling shows up.
    task automatic applyStimulus(input int n, input logic [127:0] base, input bit lastOnFinal,
                                 input logic [127:0] iv, input logic [255:0] key, input bit push);
        exp_t e;
        int   t;
        e.data = '0;
        e.iv   = iv;
        e.key  = key;
        e.nb   = 4'(n);
        for (int i = 0; i < n; i++) begin
            s_data  = base + 128'(i);
            s_last  = lastOnFinal && (i == n - 1);
            iv_in   = (i == 0) ? iv : ~iv;
            key_in  = (i == 0) ? key : ~key;
            s_valid = 1'b1;
            t = 0;
            while (!s_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!s_ready) begin
                failTimeout("beat_accept");
            end else begin
                if (push && i == n - 1)
                    checkOutput("valid_before_last", 256'(msg_valid), 256'(0));
                @(posedge clk); #1;
            end
            e.data[i*128 +: 128] = base + 128'(i);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (push) sbQ.push_back(e);
    endtask

    task automatic releaseMsg();
        int t;
        s_valid   = 1'b0;
        msg_ready = 1'b1;
        t = 0;
        while (!msg_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!msg_valid) failTimeout("msg_handshake");
        else begin
            @(posedge clk); #1;
        end
        msg_ready = 1'b0;
    endtask

    // Scoreboard monitor: compares the whole transaction on each handshake.
    always @(negedge clk) begin
        if (!rst && msg_valid && msg_ready) begin
            if (sbQ.size() == 0) begin
                failTimeout("unexpected_msg");
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                for (int b = 0; b < 8; b++)
                    checkOutput($sformatf("data_blk%0d", b), 256'(msg_data[b*128 +: 128]),
                                256'(e.data[b*128 +: 128]));
                checkOutput("msg_iv", 256'(msg_iv), 256'(e.iv));
                checkOutput("msg_key", msg_key, e.key);
                checkOutput("msg_nblocks", 256'(msg_nblocks), 256'(e.nb));
            end
        end
    end

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        iv_in = '0; key_in = '0; msg_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s_ready", 256'(s_ready), 256'(0));
        checkOutput("rst_msg_valid", 256'(msg_valid), 256'(0));
        checkOutput("rst_nblocks", 256'(msg_nblocks), 256'(0));
        checkOutput("rst_data_lo", 256'(msg_data[255:0]), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_s_ready", 256'(s_ready), 256'(1));

        // Full message with s_last on beat 8; IV/key change after beat 0.
        applyStimulus(8, 128'h1, 1'b1, 128'hF0, 256'hAB, 1'b1);
        checkOutput("t1_valid_rise", 256'(msg_valid), 256'(1));
        checkOutput("t1_s_ready_held", 256'(s_ready), 256'(0));
        checkOutput("t1_blk0", 256'(msg_data[127:0]), 256'(1));
        checkOutput("t1_blk7", 256'(msg_data[1023:896]), 256'(8));
        checkOutput("t1_iv", 256'(msg_iv), 256'(128'hF0));

        // Back-pressure with s_valid high for 5 cycles.
        s_data = 128'hDEAD; s_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_s_ready", 256'(s_ready), 256'(0));
            checkOutput("bp_msg_valid", 256'(msg_valid), 256'(1));
            checkOutput("bp_blk0_stable", 256'(msg_data[127:0]), 256'(1));
            checkOutput("bp_nblocks", 256'(msg_nblocks), 256'(8));
        end
        releaseMsg();
        checkOutput("rel_s_ready", 256'(s_ready), 256'(1));
        checkOutput("rel_msg_valid", 256'(msg_valid), 256'(0));
        checkOutput("rel_data_cleared", 256'(msg_data[1023:768]), 256'(0));

        // Short 3-block message, then a 2-block one that must not carry C over.
        applyStimulus(3, 128'hA, 1'b1, 128'h11, 256'h22, 1'b1);
        checkOutput("t2_nblocks", 256'(msg_nblocks), 256'(3));
        checkOutput("t2_blk2", 256'(msg_data[383:256]), 256'(128'hC));
        releaseMsg();
        applyStimulus(2, 128'h20, 1'b1, 128'h33, 256'h44, 1'b1);
        checkOutput("t2_no_residue", 256'(msg_data[383:256]), 256'(0));
        releaseMsg();

        // Full message without s_last closes itself; the next beat starts a new message.
        applyStimulus(8, 128'h100, 1'b0, 128'h55, 256'h66, 1'b1);
        checkOutput("t5_auto_close", 256'(msg_valid), 256'(1));
        releaseMsg();
        applyStimulus(1, 128'h200, 1'b1, 128'h77, 256'h88, 1'b1);
        checkOutput("t5_next_nblocks", 256'(msg_nblocks), 256'(1));
        releaseMsg();

        // Reset mid-fill discards the partial message.
        applyStimulus(4, 128'h300, 1'b0, 128'h99, 256'hAA, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_s_ready", 256'(s_ready), 256'(0));
        @(posedge clk); #1;
        checkOutput("midrst_data", 256'(msg_data[511:256]), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1, 128'h77, 1'b1, 128'hBB, 256'hCC, 1'b1);
        checkOutput("t6_nblocks", 256'(msg_nblocks), 256'(1));
        checkOutput("t6_blk3_zero", 256'(msg_data[511:384]), 256'(0));
        releaseMsg();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", 256'(sbQ.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
